// File: rtl/load_store_unit_pkg.sv
// Width codes, fault codes, FSM states and the accept-time fault check for the load/store unit.
package load_store_unit_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] FLT_OK       = 2'b00;
    localparam logic [1:0] FLT_MISALIGN = 2'b01;
    localparam logic [1:0] FLT_RANGE    = 2'b10;
    localparam logic [1:0] FLT_ILLEGAL  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_RMW_READ = 3'd2,
        ST_WRITE    = 3'd3,
        ST_RESP     = 3'd4
    } state_t;

    // Priority: illegal width code, then alignment, then address range.
    function automatic logic [1:0] access_fault(input logic        write,
                                                input logic [2:0]  funct3,
                                                input logic [31:0] addr,
                                                input logic [31:0] limit);
        logic illegal;
        logic misaligned;
        illegal    = (funct3 == 3'b011) || (funct3[2:1] == 2'b11) || (write && funct3[2]);
        misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                     ((funct3 == F3_W) && (addr[1:0] != 2'b00));
        if (illegal)
            return FLT_ILLEGAL;
        else if (misaligned)
            return FLT_MISALIGN;
        else if (addr >= limit)
            return FLT_RANGE;
        return FLT_OK;
    endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Combinational lane logic: load extract/extend and sub-word store merge, keyed by funct3 and addr[1:0].
module load_store_unit_align
    import load_store_unit_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  lane,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[{lane, 3'b000} +: 8];
        half_sel = word[{lane[1], 4'b0000} +: 16];

        case (funct3)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_BU:   load_data = {24'h0, byte_sel};
            F3_HU:   load_data = {16'h0, half_sel};
            default: load_data = word;
        endcase

        // Only the addressed lane changes; the rest of the fetched word is written back as read.
        store_word = word;
        case (funct3)
            F3_B:    store_word[{lane, 3'b000} +: 8]     = wdata[7:0];
            F3_H:    store_word[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            default: store_word = wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between MEM stage and a word-only memory: 1 cycle for faults, 2 for loads/SW, 3 for SB/SH.
// One request in flight; req_ready only in IDLE, so a held request is taken the cycle after RESP.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 65536
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [1:0]  resp_fault,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    state_t      state;
    logic [31:0] addr_q;
    logic [2:0]  funct3_q;
    logic [31:0] wdata_q;
    logic [1:0]  fault;
    logic [31:0] load_data;
    logic [31:0] store_word;

    assign fault     = access_fault(req_write, req_funct3, req_addr, MEM_BYTES);
    assign req_ready = (state == ST_IDLE) && !rst;
    assign mem_addr  = {addr_q[31:2], 2'b00};

    load_store_unit_align u_align (
        .funct3     (funct3_q),
        .lane       (addr_q[1:0]),
        .word       (mem_rdata),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .store_word (store_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            addr_q     <= '0;
            funct3_q   <= '0;
            wdata_q    <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_fault <= FLT_OK;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_wdata  <= '0;
        end else begin
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            resp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        addr_q   <= req_addr;
                        funct3_q <= req_funct3;
                        wdata_q  <= req_wdata;
                        if (fault != FLT_OK) begin
                            state      <= ST_RESP;
                            resp_valid <= 1'b1;
                            resp_fault <= fault;
                            resp_rdata <= '0;
                        end else if (!req_write) begin
                            state    <= ST_LOAD;
                            mem_read <= 1'b1;
                        end else if (req_funct3 == F3_W) begin
                            state     <= ST_WRITE;
                            mem_write <= 1'b1;
                            mem_wdata <= req_wdata;
                        end else begin
                            state    <= ST_RMW_READ;
                            mem_read <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    state      <= ST_RESP;
                    resp_valid <= 1'b1;
                    resp_rdata <= load_data;
                    resp_fault <= FLT_OK;
                end
                ST_RMW_READ: begin
                    // The merged word is formed from the read data as it is captured.
                    state     <= ST_WRITE;
                    mem_write <= 1'b1;
                    mem_wdata <= store_word;
                end
                ST_WRITE: begin
                    state      <= ST_RESP;
                    resp_valid <= 1'b1;
                    resp_rdata <= '0;
                    resp_fault <= FLT_OK;
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed and random checks of load_store_unit against a byte-array reference memory.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        req_ready, resp_valid, mem_read, mem_write;
    logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  resp_fault;

    bit [31:0]    mem [0:16383];
    byte unsigned ref_mem [0:65535];

    int n_checks = 0;
    int n_fail = 0;
    int wr_count = 0;
    int rv_count = 0;

    logic [31:0] last_rd, last_wd;
    logic [1:0]  last_ft;
    int          last_lat;

    load_store_unit #(.MEM_BYTES(65536)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[15:2]];

    always @(posedge clk) begin
        if (mem_write) begin
            mem[mem_addr[15:2]] <= mem_wdata;
            wr_count <= wr_count + 1;
        end
        if (resp_valid)
            rv_count <= rv_count + 1;
    end

    task automatic check(input string tag, input string what, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s.%s: observed %h expected %h", tag, what, obs, exp);
        end
    endtask

    function automatic int size_of(input int f3);
        return (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
    endfunction

    function automatic logic [1:0] ref_fault(input bit w, input int f3, input longint a);
        if (f3 == 3 || f3 >= 6 || (w && f3 >= 4)) return 2'd3;
        if (a % size_of(f3) != 0) return 2'd1;
        if (a >= 65536) return 2'd2;
        return 2'd0;
    endfunction

    function automatic logic [31:0] ref_load(input int f3, input int a);
        longint v = 0;
        int     sz = size_of(f3);
        for (int i = 0; i < sz; i++)
            v = v + (longint'(ref_mem[a + i]) << (8 * i));
        if (f3 < 4 && sz < 4 && ((v >> (8 * sz - 1)) & 1) == 1)
            v = v - (longint'(1) << (8 * sz));
        return 32'(v);
    endfunction

    function automatic logic [31:0] ref_word(input int a);
        return {ref_mem[a + 3], ref_mem[a + 2], ref_mem[a + 1], ref_mem[a]};
    endfunction

    task automatic ref_store(input int f3, input int a, input logic [31:0] d);
        for (int i = 0; i < size_of(f3); i++)
            ref_mem[a + i] = 8'(d >> (8 * i));
    endtask

    // Presents one request, waits for its response and tallies the memory activity in between.
    task automatic transact(input string tag, input bit w, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] d, output int nr, output int nw, output bit addr_bad);
        int guard = 0;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = d;
        while (!req_ready && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        check(tag, "req_ready", {31'b0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        last_lat = 1; nr = 0; nw = 0; addr_bad = 1'b0; last_wd = 32'h0;
        while (!resp_valid && last_lat < 10) begin
            nr += int'(mem_read);
            nw += int'(mem_write);
            if (mem_write) last_wd = mem_wdata;
            if ((mem_read || mem_write) && mem_addr !== {a[31:2], 2'b00}) addr_bad = 1'b1;
            @(negedge clk);
            last_lat++;
        end
        check(tag, "resp_valid", {31'b0, resp_valid}, 32'd1);
        last_rd = resp_rdata;
        last_ft = resp_fault;
    endtask

    task automatic run_op(input string tag, input bit w, input int f3, input logic [31:0] a, input logic [31:0] d);
        logic [1:0]  ef;
        logic [31:0] erd;
        int nr, nw, elat, enr, enw, widx;
        bit addr_bad;
        ef   = ref_fault(w, f3, longint'(a));
        erd  = (ef == 2'd0 && !w) ? ref_load(f3, int'(a)) : 32'h0;
        elat = (ef != 2'd0) ? 1 : (w && f3 != 2) ? 3 : 2;
        enr  = (ef == 2'd0 && (!w || f3 != 2)) ? 1 : 0;
        enw  = (ef == 2'd0 && w) ? 1 : 0;
        transact(tag, w, 3'(f3), a, d, nr, nw, addr_bad);
        check(tag, "fault", {30'b0, last_ft}, {30'b0, ef});
        check(tag, "rdata", last_rd, erd);
        check(tag, "latency", last_lat, elat);
        check(tag, "reads", nr, enr);
        check(tag, "writes", nw, enw);
        check(tag, "mem_addr", {31'b0, addr_bad}, 32'd0);
        if (ef == 2'd0 && w) ref_store(f3, int'(a), d);
        widx = int'(a[15:2]);
        check(tag, "word", mem[widx], ref_word(widx * 4));
    endtask

    initial begin
        int w0, r0, n_acc, n_pulse, dbl;
        int acc_cyc [0:3];
        bit prev_rv;

        #2 rst = 1'b1;
        #1;
        check("reset", "req_ready", {31'b0, req_ready}, 32'd0);
        check("reset", "resp_valid", {31'b0, resp_valid}, 32'd0);
        check("reset", "mem_rw", {30'b0, mem_read, mem_write}, 32'd0);
        check("reset", "mem_addr", mem_addr, 32'd0);
        check("reset", "mem_wdata", mem_wdata, 32'd0);
        check("reset", "resp", {resp_rdata[29:0], resp_fault}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1 check("reset", "ready_after", {31'b0, req_ready}, 32'd1);

        w0 = wr_count;
        run_op("sw_100", 1'b1, 2, 32'h100, 32'hDEADBEEF);
        run_op("lw_100", 1'b0, 2, 32'h100, 32'h0);
        check("lw_100", "const", last_rd, 32'hDEADBEEF);
        check("sw_lw", "write_pulses", wr_count - w0, 32'd1);

        run_op("sw_init_b", 1'b1, 2, 32'h100, 32'h11223344);
        run_op("sb_103", 1'b1, 0, 32'h103, 32'h000000A5);
        check("sb_103", "wdata_const", last_wd, 32'hA5223344);
        run_op("lb_103", 1'b0, 0, 32'h103, 32'h0);
        check("lb_103", "const", last_rd, 32'hFFFFFFA5);
        run_op("lbu_103", 1'b0, 4, 32'h103, 32'h0);
        check("lbu_103", "const", last_rd, 32'h000000A5);

        run_op("sw_init_h", 1'b1, 2, 32'h100, 32'h11223344);
        run_op("sh_102", 1'b1, 1, 32'h102, 32'h00008001);
        check("sh_102", "word_const", mem[32'h40], 32'h80013344);
        run_op("lh_102", 1'b0, 1, 32'h102, 32'h0);
        check("lh_102", "const", last_rd, 32'hFFFF8001);
        run_op("lhu_102", 1'b0, 5, 32'h102, 32'h0);
        check("lhu_102", "const", last_rd, 32'h00008001);

        run_op("lw_mis", 1'b0, 2, 32'h102, 32'h0);
        check("lw_mis", "const", {30'b0, last_ft}, 32'd1);
        run_op("sw_range", 1'b1, 2, 32'h10000, 32'h12345678);
        check("sw_range", "const", {30'b0, last_ft}, 32'd2);
        run_op("ld_f3_011", 1'b0, 3, 32'h100, 32'h0);
        check("ld_f3_011", "const", {30'b0, last_ft}, 32'd3);
        run_op("st_f3_100", 1'b1, 4, 32'h10001, 32'h0);
        check("st_f3_100", "const", {30'b0, last_ft}, 32'd3);

        // Three LW requests with req_valid held high throughout.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h100;
        n_acc = 0; n_pulse = 0; dbl = 0; prev_rv = 1'b0;
        for (int c = 0; c < 14; c++) begin
            if (req_valid && req_ready && n_acc < 4) begin
                acc_cyc[n_acc] = c;
                n_acc++;
            end
            if (resp_valid) begin
                n_pulse++;
                if (prev_rv) dbl++;
            end
            prev_rv = resp_valid;
            @(negedge clk);
            if (n_acc >= 3) req_valid = 1'b0;
        end
        check("b2b", "accepts", n_acc, 32'd3);
        if (n_acc >= 3) begin
            check("b2b", "gap1", acc_cyc[1] - acc_cyc[0], 32'd3);
            check("b2b", "gap2", acc_cyc[2] - acc_cyc[1], 32'd3);
        end
        check("b2b", "pulses", n_pulse, 32'd3);
        check("b2b", "long_pulse", dbl, 32'd0);
        check("b2b", "rdata", resp_rdata, ref_load(2, 32'h100));

        // Reset while the sub-word store sits in its read phase.
        run_op("sw_pre_rst", 1'b1, 2, 32'h100, 32'hCAFEF00D);
        @(negedge clk);
        w0 = wr_count; r0 = rv_count;
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b000; req_addr = 32'h100; req_wdata = 32'h77;
        @(negedge clk);
        req_valid = 1'b0;
        check("rst_mid", "in_rmw_read", {31'b0, mem_read}, 32'd1);
        rst = 1'b1;
        #1;
        check("rst_mid", "mem_rw_drop", {30'b0, mem_read, mem_write}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1 check("rst_mid", "ready_after", {31'b0, req_ready}, 32'd1);
        repeat (5) @(negedge clk);
        check("rst_mid", "no_write", wr_count - w0, 32'd0);
        check("rst_mid", "no_resp", rv_count - r0, 32'd0);
        check("rst_mid", "word", mem[32'h40], 32'hCAFEF00D);

        for (int k = 0; k < 40; k++) begin
            logic [31:0] a;
            bit          w;
            int          f3;
            w  = 1'($urandom_range(0, 1));
            f3 = int'($urandom_range(0, 7));
            a  = ($urandom_range(0, 7) == 0) ? 32'h10000 + $urandom_range(0, 15)
                                             : 32'h100 + $urandom_range(0, 31);
            run_op($sformatf("rnd%0d", k), w, f3, a, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the MEM pipeline stage and data memory.
- Converts core load/store requests (byte, halfword, word; signed and unsigned loads) into aligned word accesses on the memory's word-only read/write interface.
- Performs read-modify-write for sub-word stores, sign/zero-extends loads, and flags illegal, misaligned and out-of-range accesses without touching memory.
- Multi-cycle; uses a valid/ready request handshake and a one-cycle response pulse.

Parameters:
- MEM_BYTES, 65536: byte size of the backing memory. Addresses >= MEM_BYTES fault.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  core presents a request.
- req_ready  output  1  unit can accept a request; high only in IDLE with rst low.
- req_write  input  1  1 = store, 0 = load.
- req_funct3  input  3  RISC-V width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data; the low bytes are used for B/H.
- resp_valid  output  1  one-cycle response pulse.
- resp_rdata  output  32  extended load data; 0 for stores and faults.
- resp_fault  output  2  00 ok, 01 misaligned, 10 out of range, 11 illegal funct3.
- mem_read  output  1  to memory MemRead.
- mem_write  output  1  to memory MemWrite.
- mem_addr  output  32  word-aligned address {addr[31:2],2'b00}.
- mem_wdata  output  32  full word to write.
- mem_rdata  input  32  combinational read data from memory.

Behaviour:
- The request is accepted on the rising edge where req_valid && req_ready. Address, funct3, wdata and write are latched on that edge.
- FSM states: IDLE, LOAD, RMW_READ, WRITE, RESP.
- Transitions out of IDLE on accept:
  - Fault → RESP.
  - Load → LOAD.
  - SW → WRITE.
  - SB/SH → RMW_READ.
- LOAD → RESP. On the edge leaving LOAD, capture mem_rdata, extract and extend it, and register the result into resp_rdata.
- RMW_READ → WRITE. On that edge, capture mem_rdata into the merge register.
- WRITE → RESP.
- RESP → IDLE.
- No back-to-back accept: req_ready is low in the RESP cycle. A request held valid is accepted on the edge after RESP.
- Fault priority, checked at accept: illegal > misaligned > range.
  - Illegal: funct3 011, 11x, or store with 1xx.
  - Misaligned: H/HU with addr[0]=1; W with addr[1:0]≠0.
  - Range: addr >= MEM_BYTES.
- A faulting access never asserts mem_read or mem_write.
- Moore outputs:
  - mem_read = 1 in LOAD and RMW_READ.
  - mem_write = 1 in WRITE only.
  - resp_valid = 1 in RESP only.
  - mem_addr is driven from the latched address in all states.
- Latency, counted from the accept edge to the cycle with resp_valid high:
  - Fault: 1 cycle.
  - Load and SW: 2 cycles.
  - SB/SH: 3 cycles.
- Little-endian lanes: byte lane k is bits [8k+7:8k]; halfword lane addr[1].
- Extraction: B/H sign-extend; BU/HU zero-extend; W passes through.
- Merge: replace the selected lane(s) of the captured word with req_wdata[7:0] or [15:0]. Other bytes are preserved.
- resp_rdata and resp_fault hold their values until the next RESP.
- Reset values: state IDLE, resp_valid 0, resp_rdata 0, resp_fault 00, mem_read 0, mem_write 0, mem_addr 0, mem_wdata 0, all latches 0.
- Reset mid-operation: rst forces IDLE asynchronously, so mem_write drops immediately.
  - A pending RMW is abandoned and memory is unchanged.
  - No response is issued for the abandoned request.
- req_valid while not ready is ignored. The core must hold the request.

Decomposition:
- Shared include file lsu_defs.vh holds:
  - funct3 width codes;
  - fault codes;
  - FSM state encodings (3-bit localparams).
- Sub-module lsu_align (combinational) holds load extract/extend and store lane merge, keyed by funct3 and addr[1:0]. It is reused in the core for future cache integration.

Test Plan:
- Memory zeroed. SW 0x100 data 0xDEADBEEF, then LW 0x100:
  - resp_rdata 0xDEADBEEF, fault 00;
  - resp_valid 2 cycles after each accept;
  - exactly one mem_write pulse in total.
- Word 0x100 = 0x11223344. SB 0x103 data 0x000000A5:
  - one mem_read cycle then one mem_write cycle with mem_wdata 0xA5223344;
  - LB 0x103 → 0xFFFFFFA5; LBU 0x103 → 0x000000A5.
- SH 0x102 data 0x00008001 on 0x11223344:
  - memory word 0x80013344;
  - LH 0x102 → 0xFFFF8001; LHU 0x102 → 0x00008001.
- LW 0x102 → fault 01 one cycle after accept, no mem_read/mem_write. SW 0x10000 → fault 10. Load funct3 011 → fault 11. Store funct3 100 with addr 0x10001 → fault 11 (priority check).
- req_valid held high for 3 LW requests: accepts occur exactly every 3 cycles, and resp_valid is a 1-cycle pulse each time.
- SB 0x100 started, rst asserted during RMW_READ:
  - mem_write never asserted;
  - word unchanged;
  - no resp_valid;
  - req_ready high the cycle after rst deasserts.
